rgb_byte_unpacker: RTL
======================

// Module: rgb_byte_unpacker
// PURPOSE
//  Read-side consumer of the 8-bit prefetch FIFO on the HDMI board. Pops bytes
//  on rd_vld/rd_en, packs each 3-byte group into a 24-bit RGB pixel, and holds
//  up to 2 pixels. Drives pixels onto the video timing stream (de/hs/vs) with
//  1-cycle registered latency. Flags and counts underruns. Realigns byte phase
//  at each frame start.
// PARAMETERS
//  FILL_COLOR      24'h000000  pixel driven when de_in=1 and no pixel is buffered
//  UNDERRUN_CNT_W  16          width of the saturating underrun counter
// PORTS
//  rd_clk        in   1        pixel/read clock; single clock domain
//  rd_rst_n      in   1        asynchronous, active-low reset
//  fifo_rd_vld   in   1        FIFO head valid (first-word-fall-through)
//  fifo_rd_data  in   8        FIFO head byte
//  fifo_rd_en    out  1        pop; combinational; only asserted with fifo_rd_vld
//  vs_in         in   1        vertical sync from timing generator, active high
//  hs_in         in   1        horizontal sync, active high
//  de_in         in   1        data enable; one pixel consumed per de_in cycle
//  rgb_out       out  24       {R,G,B}, registered
//  vs_out        out  1        vs_in delayed 1 cycle
//  hs_out        out  1        hs_in delayed 1 cycle
//  de_out        out  1        de_in delayed 1 cycle
//  underrun      out  1        sticky; set on any underrun
//  underrun_cnt  out  UNDERRUN_CNT_W  saturating count of underrun cycles
//  clr_underrun  in   1        synchronous clear of underrun and underrun_cnt
// BEHAVIOUR
//  Reset: all registered outputs 0. phase=0, pix_cnt=0. vs_d=0. fifo_rd_en forced 0.
//  Assembler: phase 0/1/2 captures R [23:16], G [15:8], B [7:0].
//   - Pop occurs when fifo_rd_en=1. Phase advances 0->1->2->0.
//   - A pop at phase 2 pushes {R,G,byte} into the 2-entry pixel buffer.
//  Flow control:
//   - stall = (phase==2) && (pix_cnt==2) && !pix_pop
//   - fifo_rd_en = fifo_rd_vld && !stall && !flush && rd_rst_n
//   - Push and pop in the same cycle with buffer full is legal; pix_cnt is unchanged.
//  Output (registered, latency 1 from de_in):
//   - pix_pop = de_in && pix_cnt!=0 && !flush. rgb_out <= buffer head.
//   - de_in && pix_cnt==0: rgb_out <= FILL_COLOR. This is an underrun.
//   - No bypass: a pixel pushed in cycle N is usable from cycle N+1.
//   - de_in=0: rgb_out <= 0.
//  Frame realign:
//   - flush = vs_in && !vs_d, i.e. the rising edge of vs_in. vs_d is reset to 0.
//   - On flush: phase<=0, partial R/G discarded, pix_cnt<=0, no FIFO pop that cycle.
//   - If de_in coincides with flush: rgb_out<=FILL_COLOR, no underrun counted.
//  Underrun: underrun<=1 and underrun_cnt+=1, saturating at all-ones.
//   - clr_underrun clears both.
//   - clr_underrun together with a new underrun: underrun=1, cnt=1.
//  Reset mid-line: all state cleared immediately. The next pixel comes from the
//   next 3 bytes after reset release; byte alignment is regained at next vs edge.
//  Pixel buffer:
//   - Pointers are 1-bit and wrap. pix_cnt is 2-bit, range 0..2.
//   - Never push when full without a pop.
// TESTING
//  1 Bytes 11,22,33,44,55,66 present, de_in held 0: 2 pixels buffered.
//    fifo_rd_en drops only at the 3rd byte of pixel 3. Then de_in=1 for 2 cycles:
//    rgb_out=112233 then 445566, each 1 cycle after de_in.
//  2 FIFO empty, de_in=1 for 3 cycles: rgb_out=FILL_COLOR x3.
//    underrun=1, underrun_cnt=3. Then clr_underrun: both 0.
//  3 Feed AA,BB then vs_in rise, then 01,02,03, then de_in:
//    rgb_out=010203 (AA,BB discarded). fifo_rd_en=0 in the vs edge cycle.
//  4 Buffer full (2 pixels), phase 2, de_in=1 with byte valid:
//    push and pop in the same cycle. pix_cnt stays 2; no byte lost.
//  5 Drive underrun with clr_underrun=1 in the same cycle: underrun=1, cnt=1.
//    Force 2^W+5 underruns: cnt saturates at all-ones.
//  6 Assert rd_rst_n=0 mid-line with 1 pixel plus 1 byte buffered:
//    all outputs 0 immediately, fifo_rd_en=0. After release the first pixel
//    is built from the next 3 popped bytes.

Source files
------------

// File: rtl/rgb_byte_unpacker.sv
// Read-side FIFO consumer: packs 3 bytes per 24-bit RGB pixel into a 2-entry buffer
// and drives pixels onto the video timing stream with 1-cycle registered latency.
module rgb_byte_unpacker #(
  parameter logic [23:0] FILL_COLOR     = 24'h000000,
  parameter int unsigned UNDERRUN_CNT_W = 16
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst_n,
  input  logic                      fifo_rd_vld,
  input  logic [7:0]                fifo_rd_data,
  output logic                      fifo_rd_en,
  input  logic                      vs_in,
  input  logic                      hs_in,
  input  logic                      de_in,
  output logic [23:0]               rgb_out,
  output logic                      vs_out,
  output logic                      hs_out,
  output logic                      de_out,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
  input  logic                      clr_underrun
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CNT_W = UNDERRUN_CNT_W;

  typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_B = 2'd2} phase_e;

  phase_e             phase_q, phase_d;
  logic [7:0]         r_q, r_d, g_q, g_d;
  logic [PIX_W-1:0]   pix_buf_q [2];
  logic [PIX_W-1:0]   pix_buf_d [2];
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         pix_cnt_q, pix_cnt_d;
  logic               vs_d_q, vs_d_d;
  logic [PIX_W-1:0]   rgb_out_q, rgb_out_d;
  logic               vs_out_q, hs_out_q, de_out_q;
  logic               underrun_q, underrun_d;
  logic [CNT_W-1:0]   underrun_cnt_q, underrun_cnt_d;

  logic flush_c, pix_pop_c, stall_c, push_c, underrun_ev_c;

  // Flow control: frame-start flush, buffer-full stall, read pop
  always_comb begin
    flush_c       = vs_in & ~vs_d_q;
    pix_pop_c     = de_in & (pix_cnt_q != 2'd0) & ~flush_c;
    stall_c       = (phase_q == PH_B) & (pix_cnt_q == 2'd2) & ~pix_pop_c;
    fifo_rd_en    = fifo_rd_vld & ~stall_c & ~flush_c & rd_rst_n;
    push_c        = fifo_rd_en & (phase_q == PH_B);
    underrun_ev_c = de_in & (pix_cnt_q == 2'd0) & ~flush_c;
  end

  // Next-state: byte assembly, pixel buffer, output pixel, underrun tracking
  always_comb begin
    phase_d        = phase_q;
    r_d            = r_q;
    g_d            = g_q;
    pix_buf_d      = pix_buf_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    pix_cnt_d      = pix_cnt_q;
    vs_d_d         = vs_in;
    rgb_out_d      = '0;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;

    if (flush_c) begin
      phase_d   = PH_R;
      wr_ptr_d  = 1'b0;
      rd_ptr_d  = 1'b0;
      pix_cnt_d = 2'd0;
    end else begin
      if (fifo_rd_en) begin
        case (phase_q)
          PH_R: begin
            r_d     = fifo_rd_data;
            phase_d = PH_G;
          end
          PH_G: begin
            g_d     = fifo_rd_data;
            phase_d = PH_B;
          end
          PH_B: begin
            pix_buf_d[wr_ptr_q] = {r_q, g_q, fifo_rd_data};
            wr_ptr_d            = ~wr_ptr_q;
            phase_d             = PH_R;
          end
          default: phase_d = PH_R;
        endcase
      end
      if (pix_pop_c) rd_ptr_d = ~rd_ptr_q;
      case ({push_c, pix_pop_c})
        2'b10:   pix_cnt_d = pix_cnt_q + 2'd1;
        2'b01:   pix_cnt_d = pix_cnt_q - 2'd1;
        default: pix_cnt_d = pix_cnt_q;
      endcase
    end

    // Reads the pre-edge head, so a pixel pushed this cycle is not bypassed
    if (de_in) rgb_out_d = pix_pop_c ? pix_buf_q[rd_ptr_q] : FILL_COLOR;

    if (clr_underrun) begin
      underrun_d     = underrun_ev_c;
      underrun_cnt_d = underrun_ev_c ? CNT_W'(1) : '0;
    end else if (underrun_ev_c) begin
      underrun_d = 1'b1;
      if (underrun_cnt_q != {CNT_W{1'b1}}) underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      phase_q        <= PH_R;
      r_q            <= '0;
      g_q            <= '0;
      pix_buf_q[0]   <= '0;
      pix_buf_q[1]   <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      pix_cnt_q      <= 2'd0;
      vs_d_q         <= 1'b0;
      rgb_out_q      <= '0;
      vs_out_q       <= 1'b0;
      hs_out_q       <= 1'b0;
      de_out_q       <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      phase_q        <= phase_d;
      r_q            <= r_d;
      g_q            <= g_d;
      pix_buf_q      <= pix_buf_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      pix_cnt_q      <= pix_cnt_d;
      vs_d_q         <= vs_d_d;
      rgb_out_q      <= rgb_out_d;
      vs_out_q       <= vs_in;
      hs_out_q       <= hs_in;
      de_out_q       <= de_in;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign rgb_out      = rgb_out_q;
  assign vs_out       = vs_out_q;
  assign hs_out       = hs_out_q;
  assign de_out       = de_out_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
